// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies, div-by-zero result.
// Ops 6/7 (madd/maddu) only take effect when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MADDU = 3'd7
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Divide by zero: quotient all ones, remainder is the dividend
  localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

  function automatic logic op_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, src_a, src_b, input  busy, hi, lo);
  modport slave  (input  start, md_op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational result generation {nhi,nlo} for mult/div (and madd/maddu when MDU_MADD_EN is defined).
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
`ifdef MDU_MADD_EN
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
`endif
  output logic [31:0] nhi_o,
  output logic [31:0] nlo_o
);

  logic        sgn;
  logic [63:0] ext_a, ext_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur, q, r;

  assign sgn = op_signed(op_i);

  // One 64-bit multiplier serves signed and unsigned; the low 64 bits are exact for both
  assign ext_a = {{32{sgn & src_a_i[31]}}, src_a_i};
  assign ext_b = {{32{sgn & src_b_i[31]}}, src_b_i};
  assign prod  = ext_a * ext_b;

  // Signed divide via magnitudes; -2^31/-1 falls out as 0x8000_0000 rem 0
  assign a_neg = sgn & src_a_i[31];
  assign b_neg = sgn & src_b_i[31];
  assign a_mag = a_neg ? -src_a_i : src_a_i;
  assign b_mag = b_neg ? -src_b_i : src_b_i;
  assign uq    = a_mag / b_mag;
  assign ur    = a_mag % b_mag;
  assign q     = (a_neg ^ b_neg) ? -uq : uq;
  assign r     = a_neg ? -ur : ur;

  always_comb begin
    nhi_o = '0;
    nlo_o = '0;
    case (op_i)
      MD_MULT, MD_MULTU: {nhi_o, nlo_o} = prod;
      MD_DIV, MD_DIVU: begin
        if (src_b_i == '0) begin
          nhi_o = src_a_i;
          nlo_o = DIVZ_LO;
        end else begin
          nhi_o = r;
          nlo_o = q;
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: {nhi_o, nlo_o} = {hi_i, lo_i} + prod;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy stalls readers until the result lands.
// MDU_MADD_EN enables madd/maddu accumulate into {hi,lo}.
module mdu_core
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   nhi_q, nhi_d, nlo_q, nlo_d;
  logic [31:0]   ar_hi, ar_lo;
  logic          busy;
  md_op_e        op;

  assign op   = md_op_e'(md.md_op);
  assign busy = (cnt_q != '0);

  mdu_arith u_arith (
    .op_i    (op),
    .src_a_i (md.src_a),
    .src_b_i (md.src_b),
`ifdef MDU_MADD_EN
    .hi_i    (hi_q),
    .lo_i    (lo_q),
`endif
    .nhi_o   (ar_hi),
    .nlo_o   (ar_lo)
  );

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    nhi_d = nhi_q;
    nlo_d = nlo_q;
    if (busy) begin
      // Starts while busy are dropped; the last count commits the shadow result
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d = nhi_q;
        lo_d = nlo_q;
      end
    end else if (md.start) begin
      case (op)
        MD_MULT, MD_MULTU: begin
          cnt_d = CW'(MULT_CYCLES);
          nhi_d = ar_hi;
          nlo_d = ar_lo;
        end
`ifdef MDU_MADD_EN
        MD_MADD, MD_MADDU: begin
          cnt_d = CW'(MULT_CYCLES);
          nhi_d = ar_hi;
          nlo_d = ar_lo;
        end
`endif
        MD_DIV, MD_DIVU: begin
          cnt_d = CW'(DIV_CYCLES);
          nhi_d = ar_hi;
          nlo_d = ar_lo;
        end
        MD_MTHI: hi_d = md.src_a;
        MD_MTLO: lo_d = md.src_a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      nhi_q <= '0;
      nlo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      nhi_q <= nhi_d;
      nlo_q <= nlo_d;
    end
  end

  assign md.busy = busy;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
